// File: rtl/tof_pkg.sv
// Shared VL53L0X constants, FSM state encoding and counter sizing for the range poller.
package tof_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_START,
        S_WAIT_DONE,
        S_POP,
        S_CAPTURE,
        S_PUBLISH,
        S_FAIL,
        S_DRAIN,
        S_DRAIN_WAIT,
        S_WAIT_POLL
    } state_t;

    localparam logic [6:0]  VL53_DEV_ADDR     = 7'h29;
    localparam logic [7:0]  VL53_RESULT_RANGE = 8'h1E;
    localparam logic [15:0] RANGE_OOR         = 16'h1FFE;
    localparam int          BYTE_CNT_W        = 4;

    function automatic int timer_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; expired_o is high once the count has reached zero.
module cycle_timer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_value_i,
    output logic             expired_o
);

    logic [WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= load_value_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign expired_o = (count_q == '0);

endmodule

// File: rtl/tof_range_poller.sv
// Periodic VL53L0X range poller wrapped around an I2C register-read FSM and its read FIFO.
// Publishes a big-endian distance with a one-cycle valid pulse and counts failed reads.
module tof_range_poller
    import tof_pkg::*;
#(
    parameter int         POLL_CYCLES = 2_700_000,
    parameter int         WDOG_CYCLES = 270_000,
    parameter logic [6:0] DEV_ADDR    = VL53_DEV_ADDR,
    parameter logic [7:0] RANGE_REG   = VL53_RESULT_RANGE,
    parameter int         NUM_BYTES   = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic        rd_start,
    output logic [6:0]  rd_dev_address,
    output logic [7:0]  rd_reg_address,
    output logic [3:0]  rd_byte_width,
    input  logic        rd_done,
    input  logic        rd_failure,
    input  logic [7:0]  fifo_data,
    output logic        fifo_read_en,
    input  logic        fifo_empty,
    input  logic        fifo_read_valid,
    output logic [15:0] range_mm,
    output logic        range_valid,
    output logic        range_oor,
    output logic [7:0]  error_count,
    output logic        busy
);

    localparam int POLL_W = timer_width(POLL_CYCLES);
    localparam int WDOG_W = timer_width(WDOG_CYCLES);

    state_t                  state_q;
    logic [15:0]             acc_q;
    logic [15:0]             acc_d;
    logic [BYTE_CNT_W-1:0]   byte_cnt_q;
    logic [BYTE_CNT_W-1:0]   byte_cnt_d;
    logic                    rd_start_q;
    logic                    fifo_read_en_q;
    logic [15:0]             range_mm_q;
    logic                    range_valid_q;
    logic                    range_oor_q;
    logic [7:0]              error_count_q;
    logic                    poll_expired;
    logic                    wdog_expired;

    // Poll timer holds its reload value until WAIT_POLL; watchdog arms in START and spans
    // both the wait for done and every byte capture.
    cycle_timer #(.WIDTH(POLL_W)) u_poll_timer (
        .clk          (clk),
        .reset        (reset),
        .load_i       (state_q != S_WAIT_POLL),
        .load_value_i (POLL_W'(POLL_CYCLES)),
        .expired_o    (poll_expired)
    );

    cycle_timer #(.WIDTH(WDOG_W)) u_wdog_timer (
        .clk          (clk),
        .reset        (reset),
        .load_i       (state_q == S_START),
        .load_value_i (WDOG_W'(WDOG_CYCLES)),
        .expired_o    (wdog_expired)
    );

    assign acc_d      = {acc_q[7:0], fifo_data};
    assign byte_cnt_d = byte_cnt_q + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= S_IDLE;
            acc_q          <= '0;
            byte_cnt_q     <= '0;
            rd_start_q     <= 1'b0;
            fifo_read_en_q <= 1'b0;
            range_mm_q     <= '0;
            range_valid_q  <= 1'b0;
            range_oor_q    <= 1'b0;
            error_count_q  <= '0;
        end else begin
            rd_start_q     <= 1'b0;
            fifo_read_en_q <= 1'b0;
            range_valid_q  <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (enable) begin
                        rd_start_q <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                S_START: begin
                    byte_cnt_q <= '0;
                    state_q    <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    if (rd_failure || wdog_expired) begin
                        state_q <= S_FAIL;
                    end else if (rd_done) begin
                        state_q <= S_POP;
                    end
                end
                S_POP: begin
                    if (fifo_empty) begin
                        state_q <= S_FAIL;
                    end else begin
                        fifo_read_en_q <= 1'b1;
                        state_q        <= S_CAPTURE;
                    end
                end
                // The final byte publishes on the same edge it lands, so range_valid
                // is high while the FSM sits in PUBLISH.
                S_CAPTURE: begin
                    if (fifo_read_valid) begin
                        acc_q      <= acc_d;
                        byte_cnt_q <= byte_cnt_d;
                        if (byte_cnt_d == BYTE_CNT_W'(NUM_BYTES)) begin
                            range_mm_q    <= acc_d;
                            range_oor_q   <= (acc_d == RANGE_OOR);
                            range_valid_q <= 1'b1;
                            state_q       <= S_PUBLISH;
                        end else begin
                            state_q <= S_POP;
                        end
                    end else if (wdog_expired) begin
                        state_q <= S_FAIL;
                    end
                end
                S_PUBLISH: begin
                    state_q <= S_DRAIN;
                end
                S_FAIL: begin
                    if (error_count_q != 8'hFF) begin
                        error_count_q <= error_count_q + 8'd1;
                    end
                    state_q <= S_DRAIN;
                end
                S_DRAIN: begin
                    if (fifo_empty) begin
                        state_q <= enable ? S_WAIT_POLL : S_IDLE;
                    end else begin
                        fifo_read_en_q <= 1'b1;
                        state_q        <= S_DRAIN_WAIT;
                    end
                end
                S_DRAIN_WAIT: begin
                    if (fifo_read_valid) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_WAIT_POLL: begin
                    if (!enable) begin
                        state_q <= S_IDLE;
                    end else if (poll_expired) begin
                        rd_start_q <= 1'b1;
                        state_q    <= S_START;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign rd_start       = rd_start_q;
    assign rd_dev_address = DEV_ADDR;
    assign rd_reg_address = RANGE_REG;
    assign rd_byte_width  = 4'(NUM_BYTES);
    assign fifo_read_en   = fifo_read_en_q;
    assign range_mm       = range_mm_q;
    assign range_valid    = range_valid_q;
    assign range_oor      = range_oor_q;
    assign error_count    = error_count_q;
    assign busy           = (state_q != S_IDLE) && (state_q != S_WAIT_POLL);

endmodule

// File: tb/tb_tof_range_poller.sv
// Scoreboard bench for tof_range_poller: behavioural read FSM + FIFO driver, independent monitor.
module tb_tof_range_poller;

    localparam int POLL      = 100;
    localparam int WDOG      = 50;
    localparam int NUM       = 2;
    localparam int LATENCY   = 3 * NUM + 1;
    localparam int K_DONE    = 0;
    localparam int K_FAIL    = 1;
    localparam int K_TIMEOUT = 2;

    typedef struct {
        bit          aborted;
        int          expValid;
        logic [15:0] rangeMm;
        logic        rangeOor;
        logic [7:0]  errCount;
    } txn_t;

    logic        clk             = 1'b0;
    logic        reset           = 1'b1;
    logic        enable          = 1'b0;
    logic        rd_done         = 1'b0;
    logic        rd_failure      = 1'b0;
    logic [7:0]  fifo_data       = 8'h00;
    logic        fifo_empty      = 1'b1;
    logic        fifo_read_valid = 1'b0;
    logic        rd_start;
    logic [6:0]  rd_dev_address;
    logic [7:0]  rd_reg_address;
    logic [3:0]  rd_byte_width;
    logic        fifo_read_en;
    logic [15:0] range_mm;
    logic        range_valid;
    logic        range_oor;
    logic [7:0]  error_count;
    logic        busy;

    int          checks = 0;
    int          errors = 0;
    txn_t        expQ[$];
    int          rdIdx = 0;
    logic [7:0]  fifoQ[$];
    logic [7:0]  stimBytes[$];
    bit          sawStart = 1'b0;
    logic [15:0] modelRange = 16'h0000;
    logic        modelOor = 1'b0;
    logic [7:0]  modelErr = 8'h00;
    txn_t        abortRec;
    txn_t        curTxn;
    bit          prevReset = 1'b0;
    bit          prevBusy = 1'b0;
    bit          prevStart = 1'b0;
    bit          prevEnable = 1'b0;
    bit          prevRdEn = 1'b0;
    bit          expectStart = 1'b0;
    bit          gapArmed = 1'b0;
    int          cycle = 0;
    int          gap = 0;
    int          doneCycle = -1000;
    int          validCnt = 0;
    int          waitCnt = 0;

    tof_range_poller #(
        .POLL_CYCLES (POLL),
        .WDOG_CYCLES (WDOG),
        .NUM_BYTES   (NUM)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .enable          (enable),
        .rd_start        (rd_start),
        .rd_dev_address  (rd_dev_address),
        .rd_reg_address  (rd_reg_address),
        .rd_byte_width   (rd_byte_width),
        .rd_done         (rd_done),
        .rd_failure      (rd_failure),
        .fifo_data       (fifo_data),
        .fifo_read_en    (fifo_read_en),
        .fifo_empty      (fifo_empty),
        .fifo_read_valid (fifo_read_valid),
        .range_mm        (range_mm),
        .range_valid     (range_valid),
        .range_oor       (range_oor),
        .error_count     (error_count),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
        end
    endtask

    task automatic checkMin(input string name, input int actual, input int minimum);
        checks++;
        if (actual < minimum) begin
            errors++;
            $display("[TB] FAIL %s actual=%0d expected>=%0d", name, actual, minimum);
        end
    endtask

    // One clock of the behavioural FIFO: a pop requested this cycle returns data one cycle later.
    task automatic step();
        bit popNow;
        @(negedge clk);
        popNow   = fifo_read_en;
        sawStart = rd_start;
        @(posedge clk);
        #1;
        fifo_read_valid = 1'b0;
        if (popNow && fifoQ.size() != 0) begin
            fifo_data       = fifoQ.pop_front();
            fifo_read_valid = 1'b1;
        end
        if (reset) begin
            fifoQ.delete();
            fifo_read_valid = 1'b0;
        end
        fifo_empty = (fifoQ.size() == 0);
        rd_done    = 1'b0;
        rd_failure = 1'b0;
    endtask

    task automatic waitStart();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!sawStart && n < 500);
        checkOutput("startSeen", sawStart, 1);
    endtask

    task automatic setBytes(input int n, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2);
        stimBytes.delete();
        if (n > 0) stimBytes.push_back(b0);
        if (n > 1) stimBytes.push_back(b1);
        if (n > 2) stimBytes.push_back(b2);
    endtask

    // Waits for the next start, predicts the outcome, then plays the read FSM's response.
    task automatic applyStimulus(input int kind, input int delay, input bit both, input bit dropEnable);
        txn_t t;
        waitStart();
        if (dropEnable) enable = 1'b0;
        if (kind == K_DONE && stimBytes.size() >= NUM) begin
            modelRange = {stimBytes[0], stimBytes[1]};
            modelOor   = (modelRange == 16'h1FFE);
            t.expValid = 1;
        end else begin
            if (modelErr != 8'hFF) modelErr = modelErr + 8'd1;
            t.expValid = 0;
        end
        t.aborted  = 1'b0;
        t.rangeMm  = modelRange;
        t.rangeOor = modelOor;
        t.errCount = modelErr;
        expQ.push_back(t);
        repeat (delay) step();
        if (kind != K_TIMEOUT) begin
            foreach (stimBytes[i]) fifoQ.push_back(stimBytes[i]);
            fifo_empty = (fifoQ.size() == 0);
            rd_done    = (kind == K_DONE) || both;
            rd_failure = (kind == K_FAIL);
        end
        step();
    endtask

    initial begin
        int r;
        int nb;
        $display("[TB] starting tof_range_poller bench");
        repeat (3) step();
        reset = 1'b0;
        step();
        enable = 1'b1;

        setBytes(2, 8'h01, 8'h2C, 8'h00); applyStimulus(K_DONE, 3, 1'b0, 1'b0);
        setBytes(2, 8'h1F, 8'hFE, 8'h00); applyStimulus(K_DONE, 1, 1'b0, 1'b0);
        setBytes(2, 8'h00, 8'h64, 8'h00); applyStimulus(K_DONE, 5, 1'b0, 1'b0);
        setBytes(0, 8'h00, 8'h00, 8'h00); applyStimulus(K_FAIL, 2, 1'b0, 1'b0);
        setBytes(0, 8'h00, 8'h00, 8'h00); applyStimulus(K_TIMEOUT, 0, 1'b0, 1'b0);
        setBytes(1, 8'h55, 8'h00, 8'h00); applyStimulus(K_DONE, 2, 1'b0, 1'b0);
        setBytes(2, 8'h77, 8'h66, 8'h00); applyStimulus(K_FAIL, 1, 1'b1, 1'b0);
        setBytes(3, 8'hAA, 8'hBB, 8'hCC); applyStimulus(K_DONE, 4, 1'b0, 1'b0);

        repeat (40) step();
        enable = 1'b0;
        repeat (10) step();
        enable = 1'b1;
        setBytes(2, 8'h03, 8'hE8, 8'h00); applyStimulus(K_DONE, 2, 1'b0, 1'b1);
        repeat (250) step();
        enable = 1'b1;

        for (int k = 0; k < 40; k++) begin
            r  = $urandom_range(0, 9);
            nb = 2;
            if (r == 6) nb = 3;
            if (r == 7) nb = $urandom_range(0, 1);
            if (r == 8) nb = $urandom_range(0, 2);
            setBytes(nb, 8'($urandom), 8'($urandom), 8'($urandom));
            if (r < 6 && $urandom_range(0, 7) == 0) setBytes(2, 8'h1F, 8'hFE, 8'h00);
            if (r <= 7)      applyStimulus(K_DONE, $urandom_range(0, 8), 1'b0, 1'b0);
            else if (r == 8) applyStimulus(K_FAIL, $urandom_range(0, 8), 1'($urandom_range(0, 1)), 1'b0);
            else             applyStimulus(K_TIMEOUT, 0, 1'b0, 1'b0);
        end

        waitStart();
        abortRec.aborted  = 1'b1;
        abortRec.expValid = 0;
        abortRec.rangeMm  = 16'h0000;
        abortRec.rangeOor = 1'b0;
        abortRec.errCount = 8'h00;
        expQ.push_back(abortRec);
        modelRange = 16'h0000;
        modelOor   = 1'b0;
        modelErr   = 8'h00;
        fifoQ.push_back(8'h12);
        fifoQ.push_back(8'h34);
        fifo_empty = 1'b0;
        rd_done    = 1'b1;
        step();
        step();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;

        setBytes(0, 8'h00, 8'h00, 8'h00);
        for (int k = 0; k < 256; k++) begin
            applyStimulus(K_FAIL, 1, 1'b0, 1'b0);
        end
        setBytes(2, 8'h02, 8'h58, 8'h00); applyStimulus(K_DONE, 2, 1'b0, 1'b1);

        waitCnt = 0;
        while ((rdIdx < expQ.size() || busy) && waitCnt < 600) begin
            step();
            waitCnt++;
        end
        checkOutput("allRetired", rdIdx, expQ.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Monitor: protocol rules every cycle, scoreboard pops whenever a transaction retires.
    initial begin
        forever begin
            @(negedge clk);
            cycle++;
            gap++;
            if (prevReset) begin
                checkOutput("resetRdStart", rd_start, 0);
                checkOutput("resetFifoRdEn", fifo_read_en, 0);
                checkOutput("resetValid", range_valid, 0);
                checkOutput("resetOor", range_oor, 0);
                checkOutput("resetBusy", busy, 0);
                checkOutput("resetRange", range_mm, 0);
                checkOutput("resetErrCount", error_count, 0);
                checkOutput("devAddr", rd_dev_address, 7'h29);
                checkOutput("regAddr", rd_reg_address, 8'h1E);
                checkOutput("byteWidth", rd_byte_width, NUM);
            end
            if (expectStart) checkOutput("startAfterEnable", rd_start, 1);
            expectStart = !reset && !prevReset && enable && !prevEnable;
            if (rd_start) begin
                checkOutput("startPulseWidth", prevStart, 0);
                checkOutput("startNeedsEnable", prevEnable, 1);
                if (gapArmed) checkMin("pollGap", gap, POLL);
                gapArmed = 1'b1;
                gap      = 0;
            end
            if (!enable || reset) gapArmed = 1'b0;
            if (fifo_read_en) begin
                checkOutput("popNotEmpty", fifo_empty, 0);
                checkOutput("popOutstanding", prevRdEn, 0);
            end
            if (rd_done && !rd_failure) doneCycle = cycle;
            if (range_valid) begin
                validCnt++;
                checkOutput("validLatency", cycle - doneCycle, LATENCY);
                if (rdIdx < expQ.size()) begin
                    checkOutput("rangeMm", range_mm, expQ[rdIdx].rangeMm);
                    checkOutput("rangeOor", range_oor, expQ[rdIdx].rangeOor);
                end else begin
                    checkOutput("validWithoutTxn", range_valid, 0);
                end
            end
            if (prevBusy && !busy) begin
                if (rdIdx < expQ.size()) begin
                    curTxn = expQ[rdIdx];
                    rdIdx++;
                    checkOutput("validCount", validCnt, curTxn.expValid);
                    checkOutput("errorCount", error_count, curTxn.errCount);
                    checkOutput("rangeHeld", range_mm, curTxn.rangeMm);
                    checkOutput("oorHeld", range_oor, curTxn.rangeOor);
                    if (!curTxn.aborted) checkOutput("fifoDrained", fifo_empty, 1);
                end else begin
                    checkOutput("busyWithoutTxn", busy, 1);
                end
                validCnt = 0;
            end
            prevReset  = reset;
            prevBusy   = busy;
            prevStart  = rd_start;
            prevEnable = enable;
            prevRdEn   = fifo_read_en;
        end
    end

endmodule
